io_bus_controller: RTL and testbench
====================================

Name: io_bus_controller

Overview:
- Sequences and shares the memory-mapped keyboard I/O register block (5 words at 0x8000) between two requesters: CPU data port (requester 0) and keyboard scanner (requester 1).
- Performs round-robin arbitration, address range and alignment checking, and strobe sequencing (Read/Write/HAL).
- Captures read data and returns it with a one-cycle ack pulse.
- Sits between the MIPS load/store path and the I/O peripheral.

Parameters:
- BASE_ADDR, 32'h0000_8000, byte address of I/O word 0
- NUM_WORDS, 5, number of 32-bit I/O words implemented
- ACC_CYCLES, 2, cycles strobes are held per access (min 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- req  in  2  per-requester request; held high until ack
- we  in  2  per-requester 1=write, 0=read
- hal  in  2  per-requester byte access (1) vs word access (0)
- addr0, addr1  in  32 each  byte address per requester
- wdata0, wdata1  in  32 each  write data per requester
- ack  out  2  one-cycle completion pulse per requester
- err  out  1  valid with ack; 1 = access rejected
- rdata  out  32  read data, valid with ack
- io_address  out  32  to peripheral address
- io_writeData  out  32  to peripheral write data
- io_Read, io_Write, io_HAL  out  1 each  peripheral strobes
- io_readData  in  32  from peripheral

Interface rule (already decided): one clock; reset is asynchronous and active-high; clock port clk, reset port rst.

Behaviour:
- Reset values: state=IDLE, ack=0, err=0, rdata=0, io_Read=0, io_Write=0, io_HAL=0, io_address=0, io_writeData=0, rr pointer=1 (requester 0 wins the first tie).
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is set, grant a requester.
  - One request set: grant it.
  - Both set: grant the requester not granted last.
  - Latch grant, we, hal, addr, wdata into holding registers; update the rr pointer.
- Legality check in IDLE: off = addr - BASE_ADDR (32-bit unsigned).
  - Legal iff off < 4*NUM_WORDS, and for word access off[1:0] == 0.
  - Legal -> ACCESS. Illegal -> DONE with err=1; no strobe is ever asserted.
- ACCESS: lasts exactly ACC_CYCLES cycles; the cycle counter clears on entry.
  - Drive io_address = latched addr, io_HAL = latched hal.
  - Write: io_Write=1, io_Read=0, io_writeData = wdata (byte access: wdata[7:0] zero-extended).
  - Read: io_Read=1, io_Write=0.
  - On the last ACCESS cycle, register io_readData into rdata.
    - Word access: full 32 bits.
    - Byte access: {24'b0, io_readData[7:0]}.
  - Writes leave rdata unchanged.
  - Next state: DONE.
- DONE: one cycle; ack[grant]=1, err valid; all strobes 0; next state IDLE.
- Outside ACCESS: io_Read=io_Write=io_HAL=0; io_address and io_writeData hold their last values (avoids spurious peripheral address events).
- Latency: request to ack = ACC_CYCLES+2 cycles when legal, 2 cycles when illegal. Back-to-back grant possible the cycle after DONE.
- Requester protocol:
  - Fields must be stable while req is high.
  - A req still high in the cycle after ack is a new request.
  - A requester that drops req before ack has its access completed anyway (no abort); ack is still pulsed.
- Simultaneous events: a req arriving during ACCESS/DONE waits. Alternation is guaranteed under continuous contention.
- Reset mid-operation: strobes drop asynchronously; no ack is issued; the rr pointer returns to 1.
- The ack vector is never multi-hot. The err output is 0 when no ack is set.

Decomposition:
- Package io_pkg holds:
  - state enum {IDLE, ACCESS, DONE}
  - IO_BASE = 32'h8000, IO_WORDS = 5
  - constant for byte zero-extension mask
- Sub-module rr_arbiter2: a 2-requester round-robin arbiter with a last-grant pointer and enable input. It is purely the grant decision; the FSM pulses enable in IDLE.

Test Plan:
- Reset, then req=01, we0=1, hal0=0, addr0=0x8004, wdata0=0xDEADBEEF -> io_Write high for exactly 2 cycles with io_address=0x8004; ack=01 at cycle 4; err=0.
- Req0 read of 0x8004 (word) -> io_Read high 2 cycles; rdata=0xDEADBEEF with ack=01; err=0.
- Byte read, hal0=1, addr0=0x8005, io_readData=0x000000BE -> rdata=0x000000BE; io_HAL=1 during ACCESS.
- req=11 held continuously, legal reads -> grant order 0,1,0,1; ack alternates 01,10,01,10; no multi-hot ack.
- Illegal addr0=0x8014 word, and misaligned word at 0x8002 -> ack after 2 cycles, err=1, io_Read/io_Write never asserted.
- Assert rst during second ACCESS cycle of a write -> io_Write falls immediately; no ack; first post-reset tie grants requester 0.

Source files
------------

// File: rtl/io_bus_controller_pkg.sv
// Shared definitions for the keyboard I/O bus controller.
//   state_t    : controller FSM states
//   IO_BASE    : default byte address of I/O word 0
//   IO_WORDS   : default number of implemented 32-bit I/O words
//   BYTE_MASK  : zero-extension mask for byte (HAL) accesses
//   addr_legal : range + alignment check for a requested address
package io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] IO_BASE   = 32'h0000_8000;
  localparam int          IO_WORDS  = 5;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;

  // The offset is an unsigned 32-bit difference, so addresses below the base
  // wrap to huge offsets and fail the range test without a separate compare.
  function automatic logic addr_legal(input logic [31:0] addr, input logic hal,
                                      input logic [31:0] base, input int words);
    logic [31:0] off;
    off = addr - base;
    return (off < 32'(4 * words)) && (hal || (off[1:0] == 2'b00));
  endfunction

endpackage

// File: rtl/io_bus_controller_if.sv
// Bus bundles for the I/O bus controller.
//   io_req_if : two requesters (CPU data port = 0, keyboard scanner = 1)
//               req/we/hal per requester, addr/wdata per requester,
//               ack (one-hot pulse), err and rdata returned by the controller.
//               master = requester side, slave = controller side.
//   io_per_if : peripheral side of the I/O register block.
//               master = controller side, slave = peripheral side.
interface io_req_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  hal;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, hal, addr0, addr1, wdata0, wdata1,
                  input  ack, err, rdata);
  modport slave  (input  req, we, hal, addr0, addr1, wdata0, wdata1,
                  output ack, err, rdata);
endinterface

interface io_per_if;
  logic [31:0] io_address;
  logic [31:0] io_writeData;
  logic [31:0] io_readData;
  logic        io_Read;
  logic        io_Write;
  logic        io_HAL;

  modport master (output io_address, io_writeData, io_Read, io_Write, io_HAL,
                  input  io_readData);
  modport slave  (input  io_address, io_writeData, io_Read, io_Write, io_HAL,
                  output io_readData);
endinterface

// File: rtl/io_bus_controller_arb.sv
// Two-requester round-robin arbiter (grant decision only).
//   clk, rst : clock, asynchronous active-high reset
//   en       : commit the decision (the controller pulses this in IDLE)
//   req      : request vector
//   valid    : at least one request present
//   grant    : index of the winning requester
// The pointer remembers the last grant; on a tie the other requester wins.
// It resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       valid,
  output logic       grant
);

  logic last;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               last <= 1'b1;
    else if (en && valid)  last <= grant;
  end

endmodule

// File: rtl/io_bus_controller.sv
// Shares the memory-mapped keyboard I/O register block between two requesters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester side (req/we/hal/addr/wdata in, ack/err/rdata out)
//   per      : peripheral side (io_address/io_writeData/strobes out,
//              io_readData in)
// IDLE grants one requester and checks the address; a legal access holds the
// strobes for ACC_CYCLES cycles in ACCESS, an illegal one goes straight to
// DONE with err set. DONE pulses ack for exactly one cycle.
module io_bus_controller
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IO_BASE,
  parameter int          NUM_WORDS  = IO_WORDS,
  parameter int          ACC_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  io_req_if.slave  bus,
  io_per_if.master per
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          last_cycle;

  logic          arb_valid, arb_grant;
  logic [31:0]   sel_addr, sel_wdata;
  logic          sel_we, sel_hal, legal;

  logic          grant_q, we_q, hal_q, err_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == IDLE),
    .req   (bus.req),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  assign sel_addr   = arb_grant ? bus.addr1  : bus.addr0;
  assign sel_wdata  = arb_grant ? bus.wdata1 : bus.wdata0;
  assign sel_we     = bus.we[arb_grant];
  assign sel_hal    = bus.hal[arb_grant];
  assign legal      = addr_legal(sel_addr, sel_hal, BASE_ADDR, NUM_WORDS);
  assign last_cycle = (cnt == CW'(ACC_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_valid) next_state = legal ? ACCESS : DONE;
      ACCESS:  if (last_cycle) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Holding registers. addr_q/wdata_q double as the peripheral address and
  // write data, and are only loaded by a legal access so the peripheral never
  // sees an address change for a rejected request.
  // NOTE: these are a handful of flops, not a memory, so all of them get a
  // reset value; the outputs they drive are defined straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      hal_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (arb_valid) begin
            grant_q <= arb_grant;
            we_q    <= sel_we;
            hal_q   <= sel_hal;
            err_q   <= ~legal;
            if (legal) begin
              addr_q <= sel_addr;
              if (sel_we) wdata_q <= sel_hal ? (sel_wdata & BYTE_MASK) : sel_wdata;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_cycle && !we_q)
            rdata_q <= hal_q ? (per.io_readData & BYTE_MASK) : per.io_readData;
        end
        default: ;
      endcase
    end
  end

  // Strobes and ack decode from the state alone, so an asynchronous reset
  // drops them immediately.
  always_comb begin
    bus.ack      = 2'b00;
    bus.err      = 1'b0;
    per.io_Read  = 1'b0;
    per.io_Write = 1'b0;
    per.io_HAL   = 1'b0;
    case (state)
      ACCESS: begin
        per.io_Read  = ~we_q;
        per.io_Write = we_q;
        per.io_HAL   = hal_q;
      end
      DONE: begin
        bus.ack[grant_q] = 1'b1;
        bus.err          = err_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata        = rdata_q;
  assign per.io_address   = addr_q;
  assign per.io_writeData = wdata_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Self-checking bench for io_bus_controller: a small peripheral register file
// answers the strobes, and a transaction-level model predicts grant order,
// legality, latency and returned data.
module tb_io_bus_controller;
  import io_pkg::*;

  localparam int          ACC   = 2;
  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          WORDS = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_req_if bus ();
  io_per_if per ();

  io_bus_controller #(.BASE_ADDR(BASE), .NUM_WORDS(WORDS), .ACC_CYCLES(ACC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .per (per)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- peripheral: 5-word register file ----------------
  logic [31:0] pmem [8];
  logic [31:0] p_off, p_word;

  always_comb begin
    p_off = per.io_address - BASE;
    p_word = (p_off < 32'(4 * WORDS)) ? pmem[p_off[4:2]] : 32'h0;
    // Byte reads return the addressed lane in [7:0] with junk above it; the
    // controller must zero-extend.
    per.io_readData = per.io_HAL ? {24'hA5A5A5, p_word[{p_off[1:0], 3'b000} +: 8]} : p_word;
  end

  always @(posedge clk) begin
    if (per.io_Write) begin
      if (per.io_HAL) pmem[p_off[4:2]][{p_off[1:0], 3'b000} +: 8] <= per.io_writeData[7:0];
      else            pmem[p_off[4:2]] <= per.io_writeData;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [WORDS];
  logic [31:0] exp_rdata;
  int          model_last;

  task automatic predict(input int idx, input logic w, input logic h,
                         input logic [31:0] a, input logic [31:0] d, output bit legal);
    logic [31:0] off;
    int k, sh;
    off   = a - BASE;
    legal = (off < 4 * WORDS) && (h || (off % 4 == 0));
    model_last = idx;
    if (legal) begin
      k  = int'(off / 4);
      sh = 8 * int'(off % 4);
      if (w) begin
        if (h) exp_mem[k] = (exp_mem[k] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        else   exp_mem[k] = d;
      end else begin
        exp_rdata = h ? ((exp_mem[k] >> sh) & 32'hFF) : exp_mem[k];
      end
    end
  endtask

  // ---------------- stimulus / observation ----------------
  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    int          cycles;
    int          rd_cyc, wr_cyc, hal_cyc;
    logic [31:0] addr, wd;
    int          addr_var;
  } obs_t;

  logic        lw [2];
  logic        lh [2];
  logic [31:0] la [2];
  logic [31:0] ld [2];

  task automatic set_fields(input int idx, input logic w, input logic h,
                            input logic [31:0] a, input logic [31:0] d);
    lw[idx] = w; lh[idx] = h; la[idx] = a; ld[idx] = d;
    bus.we[idx]  = w;
    bus.hal[idx] = h;
    if (idx == 0) begin bus.addr0 = a; bus.wdata0 = d; end
    else          begin bus.addr1 = a; bus.wdata1 = d; end
  endtask

  function automatic logic [31:0] rand_addr();
    return BASE + 32'($urandom_range(0, 23)) - 32'd2;
  endfunction

  // Raises req in an IDLE cycle and watches until the ack pulse. cycles is
  // the request-to-ack latency counting both the request and the ack cycle;
  // 0 means the ack never came.
  task automatic run_txn(input logic [1:0] r, input bit drop_acked, output obs_t o);
    o = '{ack: 2'b00, err: 1'b0, rdata: 32'h0, cycles: 0, rd_cyc: 0, wr_cyc: 0,
          hal_cyc: 0, addr: 32'h0, wd: 32'h0, addr_var: 0};
    @(negedge clk);
    bus.req = r;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (per.io_Read || per.io_Write) begin
        if (o.rd_cyc + o.wr_cyc == 0) begin
          o.addr = per.io_address;
          o.wd   = per.io_writeData;
        end else if (per.io_address !== o.addr || per.io_writeData !== o.wd) begin
          o.addr_var++;
        end
      end
      o.rd_cyc  += int'(per.io_Read);
      o.wr_cyc  += int'(per.io_Write);
      o.hal_cyc += int'(per.io_HAL);
      if (bus.ack !== 2'b00) begin
        o.ack    = bus.ack;
        o.err    = bus.err;
        o.rdata  = bus.rdata;
        o.cycles = i + 1;
        break;
      end
    end
    if (drop_acked) bus.req = bus.req & ~o.ack;
  endtask

  // ---------------- always-on protocol monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ($countones(bus.ack) > 1 || (bus.ack == 2'b00 && bus.err !== 1'b0)) begin
        n_bad++;
        $display("FAIL ack_onehot_err: ack=%b err=%b, want one-hot ack and err=0 without ack",
                 bus.ack, bus.err);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 2'b00;
    set_fields(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_fields(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] v;
      v = $urandom;
      pmem[i] <= v;
      exp_mem[i] = v;
    end
    exp_rdata  = 32'h0;
    model_last = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.ack, bus.err, per.io_Read, per.io_Write, per.io_HAL} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ack=%b err=%b rd=%b wr=%b hal=%b, want all 0",
               bus.ack, bus.err, per.io_Read, per.io_Write, per.io_HAL);
    end
    n_cmp++;
    if (bus.rdata !== 32'h0 || per.io_address !== 32'h0 || per.io_writeData !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h io_address=%h io_writeData=%h, want 0",
               bus.rdata, per.io_address, per.io_writeData);
    end
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input int idx, input logic w, input logic h,
                             input logic [31:0] a, input logic [31:0] d);
    obs_t o;
    bit legal;
    logic [1:0] want_ack;
    set_fields(idx, w, h, a, d);
    set_fields(1 - idx, 1'($urandom), 1'($urandom), $urandom, $urandom);
    want_ack = 2'b01 << idx;
    run_txn(want_ack, 1'b1, o);
    predict(idx, w, h, a, d, legal);
    n_cmp++;
    if (o.ack !== want_ack) begin
      n_bad++; $display("FAIL %s ack: got %b want %b", name, o.ack, want_ack);
    end
    n_cmp++;
    if (o.err !== !legal) begin
      n_bad++; $display("FAIL %s err: got %b want %b", name, o.err, !legal);
    end
    n_cmp++;
    if (o.rdata !== exp_rdata) begin
      n_bad++; $display("FAIL %s rdata: got %h want %h", name, o.rdata, exp_rdata);
    end
    n_cmp++;
    if (o.cycles != (legal ? ACC + 2 : 2)) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, o.cycles, legal ? ACC + 2 : 2);
    end
    n_cmp++;
    if (o.rd_cyc != ((legal && !w) ? ACC : 0) || o.wr_cyc != ((legal && w) ? ACC : 0) ||
        o.hal_cyc != ((legal && h) ? ACC : 0)) begin
      n_bad++;
      $display("FAIL %s strobes: rd=%0d wr=%0d hal=%0d cycles, want rd=%0d wr=%0d hal=%0d", name,
               o.rd_cyc, o.wr_cyc, o.hal_cyc, (legal && !w) ? ACC : 0, (legal && w) ? ACC : 0,
               (legal && h) ? ACC : 0);
    end
    if (legal) begin
      n_cmp++;
      if (o.addr !== a || o.addr_var != 0) begin
        n_bad++; $display("FAIL %s io_address: got %h (%0d changes) want %h steady", name,
                          o.addr, o.addr_var, a);
      end
      if (w) begin
        n_cmp++;
        if (o.wd !== (h ? (d & 32'hFF) : d)) begin
          n_bad++; $display("FAIL %s io_writeData: got %h want %h", name, o.wd,
                            h ? (d & 32'hFF) : d);
        end
      end
    end
  endtask

  // Both requesters raise req together; each is dropped once acked.
  task automatic test_pair(input string name, input bit rand_fields, output logic [1:0] first_ack);
    obs_t o;
    bit legal;
    int w;
    for (int i = 0; i < 2; i++) begin
      if (rand_fields) set_fields(i, 1'($urandom), 1'($urandom), rand_addr(), $urandom);
      else             set_fields(i, 1'b0, 1'b0, BASE + 32'(4 * i), $urandom);
    end
    first_ack = 2'b00;
    for (int n = 0; n < 2; n++) begin
      run_txn((n == 0) ? 2'b11 : bus.req, 1'b1, o);
      if (n == 0) first_ack = o.ack;
      w = (n == 0) ? 1 - model_last : 1 - model_last;
      predict(w, lw[w], lh[w], la[w], ld[w], legal);
      n_cmp++;
      if (o.ack !== (2'b01 << w) || o.err !== !legal || o.rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL %s txn%0d: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h", name, n,
                 o.ack, o.err, o.rdata, 2'b01 << w, !legal, exp_rdata);
      end
    end
  endtask

  task automatic test_contention();
    obs_t o;
    bit legal;
    int w;
    logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    // Make requester 1 the last winner so continuous contention starts at 0.
    test_single("cont_pre", 1, 1'b0, 1'b0, BASE + 32'd12, 32'h0);
    set_fields(0, 1'b0, 1'b0, BASE + 32'(4 * $urandom_range(0, 4)), $urandom);
    set_fields(1, 1'b0, 1'b0, BASE + 32'(4 * $urandom_range(0, 4)), $urandom);
    for (int n = 0; n < 4; n++) begin
      run_txn(2'b11, 1'b0, o);
      w = 1 - model_last;
      predict(w, lw[w], lh[w], la[w], ld[w], legal);
      n_cmp++;
      if (o.ack !== order[n] || o.ack !== (2'b01 << w) || o.err !== 1'b0 ||
          o.rdata !== exp_rdata || o.cycles != ACC + 2) begin
        n_bad++;
        $display("FAIL contention%0d: ack=%b err=%b rdata=%h lat=%0d, want ack=%b err=0 rdata=%h lat=%0d",
                 n, o.ack, o.err, o.rdata, o.cycles, order[n], exp_rdata, ACC + 2);
      end
    end
    bus.req = 2'b00;
  endtask

  task automatic test_mid_reset();
    logic [1:0] first;
    bit saw_ack;
    @(negedge clk);
    // Rewrite word 0 with its current value: the first write edge still lands.
    set_fields(0, 1'b1, 1'b0, BASE, exp_mem[0]);
    bus.req = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (per.io_Write !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre: io_Write=%b want 1", per.io_Write);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (per.io_Write !== 1'b0 || per.io_Read !== 1'b0 || per.io_HAL !== 1'b0) begin
      n_bad++; $display("FAIL midrst_strobes: wr=%b rd=%b hal=%b want 0",
                        per.io_Write, per.io_Read, per.io_HAL);
    end
    bus.req = 2'b00;
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) saw_ack = 1'b1;
    end
    n_cmp++;
    if (saw_ack || bus.rdata !== 32'h0) begin
      n_bad++; $display("FAIL midrst_ack: ack seen=%b rdata=%h, want no ack and rdata 0",
                        saw_ack, bus.rdata);
    end
    rst = 1'b0;
    model_last = 1;
    exp_rdata  = 32'h0;
    test_pair("post_reset_tie", 1'b0, first);
    n_cmp++;
    if (first !== 2'b01) begin
      n_bad++; $display("FAIL post_reset_tie_first: got %b want 01", first);
    end
  endtask

  task automatic test_random();
    logic [1:0] first;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) test_pair("rand_pair", 1'b1, first);
      else test_single("rand_single", int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom),
                       rand_addr(), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single("write_word", 0, 1'b1, 1'b0, 32'h0000_8004, 32'hDEAD_BEEF);
    test_single("read_word",  0, 1'b0, 1'b0, 32'h0000_8004, 32'h0);
    test_single("read_byte",  0, 1'b0, 1'b1, 32'h0000_8005, 32'h0);
    test_single("illegal_range", 0, 1'b0, 1'b0, 32'h0000_8014, 32'h0);
    test_single("illegal_align", 0, 1'b1, 1'b0, 32'h0000_8002, 32'h1234_5678);
    test_single("below_base",    1, 1'b0, 1'b1, 32'h0000_7FFF, 32'h0);
    test_single("last_word",     1, 1'b1, 1'b0, 32'h0000_8010, 32'hCAFE_F00D);
    test_single("last_byte_wr",  0, 1'b1, 1'b1, 32'h0000_8013, 32'h0000_1177);
    test_single("last_word_rd",  1, 1'b0, 1'b0, 32'h0000_8010, 32'h0);
    test_contention();
    test_mid_reset();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
